spike_rate_decoder: RTL and testbench



---
 rtl/spike_rate_decoder.sv | 145 ++++++++++++++
 tb/tb_spike_rate_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
// Turns a neuron's spike level back into numbers: counts spike rising
// edges over a fixed window of WINDOW_CYCLES enabled cycles and offers the
// saturated count through a valid/ready handshake. A result that closes
// while the previous one is still unconsumed is dropped and flagged in the
// sticky overrun flag.
// Optional inter-spike-interval measurement is built only when the macro
// SPIKE_DECODER_ISI_EN is defined; otherwise isi_out/isi_valid are tied 0.
module spike_rate_decoder #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int COUNT_W       = 8,
  parameter int ISI_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               spike,
  output logic [COUNT_W-1:0] rate_out,
  output logic               rate_valid,
  input  logic               rate_ready,
  output logic               overrun,
  output logic [ISI_W-1:0]   isi_out,
  output logic               isi_valid
);

  localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};

  logic               spike_q_reg;
  logic [WIN_W-1:0]   win_cnt_reg;
  logic [COUNT_W-1:0] cnt_reg;
  logic [COUNT_W-1:0] rate_out_reg;
  logic               rate_valid_reg;
  logic               overrun_reg;

  logic               spike_edge;
  logic               win_close;
  logic               transfer;
  logic [COUNT_W-1:0] cnt_sum;

  // Edge detect, window-close and handshake qualifiers; the saturated sum
  // includes an edge on the final cycle so it belongs to the closing window.
  always_comb begin
    spike_edge = spike & ~spike_q_reg;
    win_close  = enable & (win_cnt_reg == WIN_LAST);
    transfer   = rate_valid_reg & rate_ready;
    cnt_sum    = cnt_reg;
    if (spike_edge && (cnt_reg != CNT_MAX)) begin
      cnt_sum = cnt_reg + COUNT_W'(1);
    end
  end

  // Previous spike level tracks every cycle, even while decoding is frozen,
  // so a level held across an enable gap is not mistaken for a new edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      spike_q_reg <= 1'b0;
    end else begin
      spike_q_reg <= spike;
    end
  end

  // Window position and running spike count; both hold while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_reg <= '0;
      cnt_reg     <= '0;
    end else if (enable) begin
      if (win_close) begin
        win_cnt_reg <= '0;
        cnt_reg     <= '0;
      end else begin
        win_cnt_reg <= win_cnt_reg + WIN_W'(1);
        cnt_reg     <= cnt_sum;
      end
    end
  end

  // Result holding register: load on close when the slot is free (or being
  // emptied this cycle), otherwise drop the new result and flag overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      rate_out_reg   <= '0;
      rate_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (win_close) begin
        if (!rate_valid_reg || transfer) begin
          rate_out_reg   <= cnt_sum;
          rate_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (transfer) begin
        rate_valid_reg <= 1'b0;
      end
    end
  end

  assign rate_out   = rate_out_reg;
  assign rate_valid = rate_valid_reg;
  assign overrun    = overrun_reg;

`ifdef SPIKE_DECODER_ISI_EN
  localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};

  logic [ISI_W-1:0] isi_cnt_reg;
  logic [ISI_W-1:0] isi_out_reg;
  logic             isi_valid_reg;
  logic             seen_first_reg;

  // Interval counter restarts at 1 on each edge; the first edge after reset
  // only arms the measurement, later edges publish the elapsed interval.
  always_ff @(posedge clk) begin
    if (reset) begin
      isi_cnt_reg    <= '0;
      isi_out_reg    <= '0;
      isi_valid_reg  <= 1'b0;
      seen_first_reg <= 1'b0;
    end else begin
      isi_valid_reg <= 1'b0;
      if (enable) begin
        if (spike_edge) begin
          if (seen_first_reg) begin
            isi_out_reg   <= isi_cnt_reg;
            isi_valid_reg <= 1'b1;
          end
          seen_first_reg <= 1'b1;
          isi_cnt_reg    <= ISI_W'(1);
        end else if (seen_first_reg && (isi_cnt_reg != ISI_MAX)) begin
          isi_cnt_reg <= isi_cnt_reg + ISI_W'(1);
        end
      end
    end
  end

  assign isi_out   = isi_out_reg;
  assign isi_valid = isi_valid_reg;
`else
  assign isi_out   = '0;
  assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized bench for spike_rate_decoder against a timestamp/integer
// reference model. A 32-cycle window lets alternating spikes (16 edges per
// window) drive the 4-bit count into saturation.
module tb_spike_rate_decoder;

  localparam int W    = 32;
  localparam int CW   = 4;
  localparam int IW   = 8;
  localparam int CMAX = 15;
  localparam int IMAX = 255;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          spike;
  logic [CW-1:0] rate_out;
  logic          rate_valid;
  logic          rate_ready;
  logic          overrun;
  logic [IW-1:0] isi_out;
  logic          isi_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers and timestamps.
  int m_prev, m_pos, m_edges, m_pend, m_rate, m_ovr;
  int m_time, m_last_edge, m_seen, m_isi, m_isiv;

  spike_rate_decoder #(
    .WINDOW_CYCLES(W),
    .COUNT_W(CW),
    .ISI_W(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .spike(spike),
    .rate_out(rate_out),
    .rate_valid(rate_valid),
    .rate_ready(rate_ready),
    .overrun(overrun),
    .isi_out(isi_out),
    .isi_valid(isi_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int obs, input int expected);
    checks++;
    if (obs != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, obs, expected, $time);
    end
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_update();
    int e, xfer, closed;
    if (reset) begin
      m_prev = 0; m_pos = 0; m_edges = 0; m_pend = 0; m_rate = 0; m_ovr = 0;
      m_time = 0; m_last_edge = 0; m_seen = 0; m_isi = 0; m_isiv = 0;
      return;
    end
    e      = (spike && !m_prev) ? 1 : 0;
    xfer   = (m_pend != 0 && rate_ready) ? 1 : 0;
    closed = 0;
    m_isiv = 0;
    if (xfer != 0) $display("xfer rate_out=%0d t=%0t", m_rate, $time);
    if (enable) begin
      m_edges += e;
      m_time++;
      if (m_pos == W - 1) begin
        closed = 1;
        if (m_pend == 0 || xfer != 0) begin
          m_rate = min_int(m_edges, CMAX);
          m_pend = 1;
        end else begin
          m_ovr = 1;
        end
        m_edges = 0;
        m_pos   = 0;
      end else begin
        m_pos++;
      end
      if (e != 0) begin
        if (m_seen != 0) begin
          m_isi  = min_int(m_time - m_last_edge, IMAX);
          m_isiv = 1;
        end
        m_seen      = 1;
        m_last_edge = m_time;
      end
    end
    if (xfer != 0 && closed == 0) m_pend = 0;
    m_prev = spike ? 1 : 0;
  endtask

  // One clock: update model at the edge, compare just after it.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_value("rate_valid", int'(rate_valid), m_pend);
    check_value("rate_out", int'(rate_out), m_rate);
    check_value("overrun", int'(overrun), m_ovr);
`ifdef SPIKE_DECODER_ISI_EN
    check_value("isi_valid", int'(isi_valid), m_isiv);
    check_value("isi_out", int'(isi_out), m_isi);
`else
    check_value("isi_valid", int'(isi_valid), 0);
    check_value("isi_out", int'(isi_out), 0);
`endif
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; spike = 1'b0; rate_ready = 1'b0;
    step();
    step();
    reset = 1'b0; enable = 1'b1; rate_ready = 1'b1;

    // Sparse single-cycle spikes, consumer always ready.
    for (int i = 0; i < 4 * W; i++) begin
      spike = ($urandom_range(0, 3) == 0) && !spike;
      step();
    end
    // Quiet window yields zero.
    spike = 1'b0;
    for (int i = 0; i < W + 2; i++) step();

    // Long held pulses plus a spike landing on assorted positions.
    for (int i = 0; i < 3 * W; i++) begin
      spike = ((i % W) >= 3 && (i % W) <= 9) || ((i % W) == W - 1);
      step();
    end

    // Alternating spikes saturate the count.
    for (int i = 0; i < 3 * W; i++) begin
      spike = (i % 2) == 0;
      step();
    end

    // Consumer stalls across several closes, then drains.
    rate_ready = 1'b0;
    for (int i = 0; i < 3 * W + 5; i++) begin
      spike = $urandom_range(0, 1) == 1;
      step();
    end
    rate_ready = 1'b1;
    for (int i = 0; i < W; i++) begin
      spike = $urandom_range(0, 1) == 1;
      step();
    end

    // Interval measurement, including a gap beyond the 8-bit range.
    spike = 1'b0;
    for (int i = 0; i < 700; i++) begin
      spike = (i == 4) || (i == 9) || (i == 300) || (i == 560) || (i == 561) || (i == 563);
      step();
    end

    // Enable gaps with spikes present.
    for (int i = 0; i < 8 * W; i++) begin
      enable = !((i % 50) >= 20 && (i % 50) < 30) && ($urandom_range(0, 9) != 0);
      spike  = $urandom_range(0, 2) == 0;
      rate_ready = $urandom_range(0, 3) != 0;
      step();
    end
    enable = 1'b1;

    // Reset in the middle of a window with a pending result.
    rate_ready = 1'b0;
    for (int i = 0; i < W + 10; i++) begin
      spike = (i % 3) == 0;
      step();
    end
    reset = 1'b1; spike = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      spike = (i % 5) == 0;
      rate_ready = i > W;
      step();
    end

    // Fully random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      reset      = $urandom_range(0, 299) == 0;
      enable     = $urandom_range(0, 7) != 0;
      spike      = $urandom_range(0, 1) == 1;
      rate_ready = $urandom_range(0, 2) != 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
